// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TEST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_LOAD     = 1'b0;
  localparam logic MODE_SELFTEST = 1'b1;

  // shift_count must reach CHAIN_LEN+3 (self-test length) without wrapping
  function automatic int count_width(input int chain_len);
    return $clog2(chain_len + 4);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that hands out NUM_CHAINS bits per shift, lowest bit group first.
// Exposes next-cycle head bits so the top can register them alongside shift_en.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int NUM_CHAINS = 1,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  active,
  input  logic                  more,
  input  logic                  shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  bit_valid_next,
  output logic [NUM_CHAINS-1:0] head_next
);

  localparam int BPW = WORD_W / NUM_CHAINS;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  // Row k holds the bits every chain receives on shift k of this word.
  typedef logic [BPW-1:0][NUM_CHAINS-1:0] word_t;

  word_t         buf_reg, buf_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          full_reg, full_next;
  logic          last_bit;

  assign last_bit = (idx_reg == IW'(BPW - 1));
  assign in_ready = active & more & (~full_reg | (shift & last_bit));

  always_comb begin
    buf_next  = buf_reg;
    idx_next  = idx_reg;
    full_next = full_reg;
    if (!active) begin
      // leaving LOAD discards whatever is left of the final word
      full_next = 1'b0;
    end else if (in_valid && in_ready) begin
      buf_next  = in_data;
      idx_next  = '0;
      full_next = 1'b1;
    end else if (shift) begin
      if (last_bit) full_next = 1'b0;
      else          idx_next  = idx_reg + IW'(1);
    end
  end

  assign bit_valid_next = full_next;
  assign head_next      = buf_next[idx_next];

  always_ff @(posedge clk) begin
    if (srst) begin
      buf_reg  <= '0;
      idx_reg  <= '0;
      full_reg <= 1'b0;
    end else begin
      buf_reg  <= buf_next;
      idx_reg  <= idx_next;
      full_reg <= full_next;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain programmer: loads NUM_CHAINS ccff chains from a word stream.
// Define CCFF_SELFTEST_EN to add the single-pulse chain-length self-test.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 29696,
  parameter int WORD_W     = 32
) (
  input  logic                              prog_clk,
  input  logic                              prog_reset,
  input  logic                              start,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_W-1:0]                 in_data,
  output logic [NUM_CHAINS-1:0]             ccff_head,
  output logic                              ccff_shift_en,
  input  logic [NUM_CHAINS-1:0]             ccff_tail,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_CHAINS-1:0]             test_fail_mask,
  output logic [count_width(CHAIN_LEN)-1:0] shift_count
);

  localparam int             CW        = count_width(CHAIN_LEN);
  localparam logic [CW-1:0]  LEN       = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  LAST_LOAD = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0]  SAT       = CW'(CHAIN_LEN + 3);

  state_t                  state_reg;
  logic                    shift_en_reg;
  logic [NUM_CHAINS-1:0]   head_reg;
  logic [CW-1:0]           count_reg;
  logic [CW-1:0]           count_inc;
  logic                    done_reg;
  logic [NUM_CHAINS-1:0]   fail_reg;

  logic                    load_shift, final_load, ser_active, more_words;
  logic                    ser_valid_next, start_test;
  logic [NUM_CHAINS-1:0]   ser_head_next;

`ifdef CCFF_SELFTEST_EN
  localparam logic [CW-1:0] LAST_TEST = CW'(CHAIN_LEN + 2);
  assign start_test = (mode == MODE_SELFTEST);
`else
  logic unused_inputs;
  assign unused_inputs = mode ^ (^ccff_tail);
  assign start_test    = 1'b0;
`endif

  assign load_shift = (state_reg == LOAD) & shift_en_reg;
  assign final_load = load_shift & (count_reg == LAST_LOAD);
  assign ser_active = (state_reg == LOAD) & ~final_load;
  // Bits already committed (issued plus the one shifting now) decide whether another word is needed.
  assign more_words = (count_reg + CW'(shift_en_reg)) < LEN;
  assign count_inc  = (count_reg == SAT) ? count_reg : count_reg + CW'(1);

  ccff_word_serializer #(
    .NUM_CHAINS (NUM_CHAINS),
    .WORD_W     (WORD_W)
  ) u_ser (
    .clk            (prog_clk),
    .srst           (prog_reset),
    .active         (ser_active),
    .more           (more_words),
    .shift          (load_shift),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .bit_valid_next (ser_valid_next),
    .head_next      (ser_head_next)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_reg    <= IDLE;
      shift_en_reg <= 1'b0;
      head_reg     <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      fail_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          shift_en_reg <= 1'b0;
          head_reg     <= '0;
          if (start) begin
            count_reg <= '0;
            fail_reg  <= '0;
            if (start_test) begin
              state_reg    <= TEST;
              shift_en_reg <= 1'b1;
              head_reg     <= '1;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (shift_en_reg) count_reg <= count_inc;
          if (final_load) begin
            state_reg    <= DONE;
            done_reg     <= 1'b1;
            shift_en_reg <= 1'b0;
            head_reg     <= '0;
          end else begin
            shift_en_reg <= ser_valid_next;
            head_reg     <= ser_head_next;
          end
        end
`ifdef CCFF_SELFTEST_EN
        TEST: begin
          count_reg <= count_inc;
          head_reg  <= '0;
          // pulse must appear exactly at k=CHAIN_LEN and be followed by two zeros
          if (count_reg == LEN)     fail_reg <= fail_reg | ~ccff_tail;
          else if (count_reg > LEN) fail_reg <= fail_reg | ccff_tail;
          if (count_reg == LAST_TEST) begin
            state_reg    <= DONE;
            done_reg     <= 1'b1;
            shift_en_reg <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg    <= IDLE;
          shift_en_reg <= 1'b0;
          head_reg     <= '0;
        end
      endcase
    end
  end

  assign ccff_head      = head_reg;
  assign ccff_shift_en  = shift_en_reg;
  assign busy           = (state_reg == LOAD) | (state_reg == TEST);
  assign done           = done_reg;
  // never set without the self-test, so it reads as constant zero there
  assign test_fail_mask = fail_reg;
  assign shift_count    = count_reg;

endmodule
